// File: rtl/fifo_dispatcher.sv
// Read-side FIFO dispatcher: pops one word at a time and delivers it to a single
// requesting reader. Readers are chosen round-robin, and the reader is held until it acks.
module fifo_dispatcher #(
    parameter int unsigned NUM_READERS = 2,
    parameter int unsigned DATA_W      = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_empty,
    input  logic [DATA_W-1:0]      i_rdata,
    output logic                   o_re,
    input  logic [NUM_READERS-1:0] i_req,
    input  logic [NUM_READERS-1:0] i_ack,
    output logic [NUM_READERS-1:0] o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_busy
);

    localparam int unsigned PTR_W = $clog2(NUM_READERS);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_READERS - 1);

    typedef enum logic [1:0] {IDLE, POP, DELIVER} state_t;

    state_t                 state, state_nxt;
    logic [PTR_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]       grant, grant_nxt;
    logic [PTR_W-1:0]       pick, idx;
    logic                   found;
    logic                   re_nxt;
    logic [NUM_READERS-1:0] valid_nxt;
    logic [DATA_W-1:0]      data_nxt;

    // Walk the request vector starting at rr_ptr, wrapping explicitly so that
    // NUM_READERS does not have to be a power of two.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = rr_ptr;
        for (int unsigned i = 0; i < NUM_READERS; i++) begin
            if (!found && i_req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        re_nxt     = 1'b0;
        valid_nxt  = o_valid;
        data_nxt   = o_data;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        unique case (state)
            IDLE: begin
                if (!i_empty && found) begin
                    grant_nxt = pick;
                    re_nxt    = 1'b1;
                    state_nxt = POP;
                end
            end
            POP: begin
                data_nxt        = i_rdata;
                valid_nxt       = '0;
                valid_nxt[grant] = 1'b1;
                state_nxt       = DELIVER;
            end
            DELIVER: begin
                if (i_ack[grant]) begin
                    valid_nxt  = '0;
                    rr_ptr_nxt = (grant == LAST) ? '0 : grant + 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            o_re    <= 1'b0;
            o_valid <= '0;
            o_data  <= '0;
            rr_ptr  <= '0;
            grant   <= '0;
        end else begin
            state   <= state_nxt;
            o_re    <= re_nxt;
            o_valid <= valid_nxt;
            o_data  <= data_nxt;
            rr_ptr  <= rr_ptr_nxt;
            grant   <= grant_nxt;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_dispatcher.sv
// Self-checking bench for fifo_dispatcher: show-ahead FIFO model plus a
// transaction-level reference (pending word, its age and reader, round-robin pointer).
module tb_fifo_dispatcher;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_empty = 1'b1;
    logic [7:0] i_rdata = '0;
    logic       o_re;
    logic [1:0] i_req = '0;
    logic [1:0] i_ack = '0;
    logic [1:0] o_valid;
    logic [7:0] o_data;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Environment FIFO contents (front is presented on i_rdata).
    logic [7:0] fifo_q[$];

    // Reference model: one outstanding transfer at most.
    bit         m_active = 0;
    int         m_age    = 0;
    int         m_win    = 0;
    int         m_rr     = 0;
    logic [7:0] m_word   = '0;
    logic [7:0] m_data   = '0;

    fifo_dispatcher #(.NUM_READERS(2), .DATA_W(8)) dut (
        .i_clk    (clk),
        .i_reset_n(i_reset_n),
        .i_empty  (i_empty),
        .i_rdata  (i_rdata),
        .o_re     (o_re),
        .i_req    (i_req),
        .i_ack    (i_ack),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_fifo();
        i_empty = (fifo_q.size() == 0);
        i_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh_fifo();
    endtask

    // Advance the reference by one clock edge using the inputs seen at that edge.
    task automatic model_edge(input logic [1:0] req, input logic [1:0] ack, input logic rst_n);
        if (!rst_n) begin
            m_active = 0;
            m_rr     = 0;
            m_data   = '0;
        end else if (!m_active) begin
            if (fifo_q.size() != 0 && req != 2'b00) begin
                for (int i = 0; i < N; i++) begin
                    if (!m_active && req[(m_rr + i) % N]) begin
                        m_win    = (m_rr + i) % N;
                        m_active = 1;
                    end
                end
                m_age  = 0;
                m_word = fifo_q[0];
            end
        end else if (m_age == 0) begin
            m_age  = 1;
            m_data = m_word;
        end else if (ack[m_win]) begin
            m_active = 0;
            m_rr     = (m_win + 1) % N;
        end
    endtask

    task automatic cycle(input logic [1:0] req, input logic [1:0] ack, input logic rst_n);
        logic       pop_now;
        logic [1:0] ev;
        i_req     = req;
        i_ack     = ack;
        i_reset_n = rst_n;
        pop_now   = o_re;
        model_edge(req, ack, rst_n);
        @(posedge clk);
        #1;
        if (pop_now === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh_fifo();
        ev = (m_active && m_age == 1) ? 2'(1 << m_win) : 2'b00;
        chk("o_re",   32'(o_re),    32'(m_active && m_age == 0));
        chk("o_valid", 32'(o_valid), 32'(ev));
        chk("o_data", 32'(o_data),  32'(m_data));
        chk("o_busy", 32'(o_busy),  32'(m_active));
        chk("valid_onehot0", 32'($onehot0(o_valid)), 32'd1);
        chk("re_while_valid", 32'(o_re && (o_valid != 2'b00)), 32'd0);
    endtask

    initial begin
        logic [1:0] r, a;
        refresh_fifo();
        #1;

        // Reset held with a non-empty FIFO and both readers requesting.
        push(8'h77);
        repeat (3) cycle(2'b11, 2'b00, 1'b0);
        chk("reset_re", 32'(o_re), 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        fifo_q.delete();
        refresh_fifo();

        // Single word to reader 0 with immediate ack.
        push(8'hA5);
        cycle(2'b01, 2'b00, 1'b1);
        chk("single_re", 32'(o_re), 32'd1);
        cycle(2'b01, 2'b00, 1'b1);
        chk("single_valid", 32'(o_valid), 32'h1);
        chk("single_data", 32'(o_data), 32'hA5);
        cycle(2'b00, 2'b01, 1'b1);
        chk("single_ack", 32'(o_valid), 32'h0);
        chk("single_rr", 32'(m_rr), 32'd1);

        // Round-robin from a fresh pointer: readers 0,1,0 receive 11,22,33.
        cycle(2'b00, 2'b00, 1'b0);
        push(8'h11); push(8'h22); push(8'h33);
        for (int w = 0; w < 3; w++) begin
            cycle(2'b11, 2'b11, 1'b1);
            cycle(2'b11, 2'b11, 1'b1);
            chk("rr_reader", 32'(o_valid), (w == 1) ? 32'h2 : 32'h1);
            chk("rr_data", 32'(o_data), 32'(8'h11 * (w + 1)));
            cycle(2'b11, 2'b11, 1'b1);
        end

        // Empty FIFO holds off the pop until a word arrives.
        repeat (10) cycle(2'b10, 2'b00, 1'b1);
        chk("empty_no_re", 32'(o_re), 32'd0);
        push(8'h5C);
        cycle(2'b10, 2'b00, 1'b1);
        chk("empty_re", 32'(o_re), 32'd1);
        cycle(2'b10, 2'b00, 1'b1);
        chk("empty_valid", 32'(o_valid), 32'h2);

        // Stall: granted reader withholds ack, other reader pulses its ack.
        for (int s = 0; s < 5; s++) cycle(2'b11, (s % 2) ? 2'b01 : 2'b00, 1'b1);
        chk("stall_valid", 32'(o_valid), 32'h2);
        chk("stall_data", 32'(o_data), 32'h5C);
        cycle(2'b11, 2'b10, 1'b1);
        chk("stall_release", 32'(o_busy), 32'd0);

        // Reset while delivering to reader 0 discards the word.
        cycle(2'b00, 2'b00, 1'b0);
        push(8'hC3); push(8'h3C);
        cycle(2'b01, 2'b00, 1'b1);
        cycle(2'b01, 2'b00, 1'b1);
        chk("mid_valid", 32'(o_valid), 32'h1);
        cycle(2'b01, 2'b00, 1'b0);
        chk("mid_reset_valid", 32'(o_valid), 32'h0);
        chk("mid_reset_data", 32'(o_data), 32'h0);
        repeat (4) cycle(2'b00, 2'b00, 1'b1);
        chk("mid_no_pop", 32'(fifo_q.size()), 32'd1);

        // Randomized traffic with occasional writes and rare resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) push(8'($urandom));
            r = 2'($urandom);
            a = 2'($urandom);
            cycle(r, a, ($urandom_range(0, 63) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
